// File: rtl/if_stage_pkg.sv
// Types and helpers shared by the instruction fetch stage and its queue.
package if_stage_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential successor of a word address; wraps naturally at 2^32.
  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/if_stage_defines.sv
// Shared width and encoding macros for the fetch datapath.
`ifndef IF_STAGE_DEFINES_SV
`define IF_STAGE_DEFINES_SV

`define AddrLen     31:0
`define InstLen     31:0
`define ZERO_WORD   32'h0000_0000
`define ChipEnable  1'b1
`define ChipDisable 1'b0

`endif

// File: rtl/if_stage_fetch_queue.sv
// Register-based circular buffer decoupling ROM fetch from decode.
`ifndef IF_STAGE_DEFINES_SV
`include "if_stage_defines.sv"
`endif

module fetch_queue
  import if_stage_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  fetch_entry_t              wdata,
  output fetch_entry_t              head,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush and reset suppress any same-cycle push/pop.
  assign do_push = push & ~flush & ~rst;
  assign do_pop  = pop  & ~flush & ~rst;

  // Head entry is a plain register read; the caller masks it when empty.
  assign head = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: pc register, ROM request and fetch queue toward decode.
`ifndef IF_STAGE_DEFINES_SV
`include "if_stage_defines.sv"
`endif

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_taken,
  input  logic [`AddrLen]  br_target,
  output logic             rom_ce,
  output logic [`AddrLen]  rom_addr,
  input  logic [`InstLen]  rom_inst,
  output logic             id_valid,
  output logic [`AddrLen]  id_pc,
  output logic [`InstLen]  id_inst,
  input  logic             id_ready
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     count;
  fetch_entry_t      head;
  fetch_entry_t      wdata;
  logic              has_entry;
  logic              full;
  logic              push;
  logic              pop;

  // Queue status and the handshake to decode.
  assign has_entry = (count != '0) & ~rst;
  assign full      = (count == CW'(QDEPTH));
  assign id_valid  = has_entry & ~br_taken;
  assign pop       = id_valid & id_ready;

  // Fetch whenever a slot is free or one is being freed this cycle.
  assign push     = ~rst & ~br_taken & (~full | pop);
  assign rom_ce   = push ? `ChipEnable : `ChipDisable;
  assign rom_addr = pc;

  assign id_pc   = has_entry ? head.pc   : `ZERO_WORD;
  assign id_inst = has_entry ? head.inst : `ZERO_WORD;

  assign wdata.pc   = pc;
  assign wdata.inst = rom_inst;

  // Program counter: reset, redirect, then sequential advance on fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (br_taken) begin
      pc <= br_target & ~ADDR_W'(3);
    end else if (push) begin
      pc <= pc_plus4(pc);
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized-handshake bench for if_stage.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  // Second instance exercising the wrap-around reset address.
  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_inst;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_inst;
  logic        w_id_ready;

  int n_cmp;
  int n_err;

  if_stage dut (
    .clk       (clk),
    .rst       (rst),
    .br_taken  (br_taken),
    .br_target (br_target),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_ready  (id_ready)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .br_taken  (w_br_taken),
    .br_target (w_br_target),
    .rom_ce    (w_rom_ce),
    .rom_addr  (w_rom_addr),
    .rom_inst  (w_rom_inst),
    .id_valid  (w_id_valid),
    .id_pc     (w_id_pc),
    .id_inst   (w_id_inst),
    .id_ready  (w_id_ready)
  );

  // ROM word k holds 32'h1000_0000 + k.
  assign rom_inst   = 32'h1000_0000 + (rom_addr >> 2);
  assign w_rom_inst = 32'h1000_0000 + (w_rom_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc;
    int          n_del;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; br_taken = 1'b0; br_target = '0; id_ready = 1'b0;
    w_br_taken = 1'b0; w_br_target = '0; w_id_ready = 1'b1;

    // Reset state.
    tick(); tick();
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_rom_ce",   32'(rom_ce),   32'd0);
    check("rst_id_pc",    id_pc,         32'd0);
    check("rst_id_inst",  id_inst,       32'd0);

    // Streaming with id_ready high.
    rst = 1'b0; id_ready = 1'b1;
    #1;
    check("first_rom_ce",   32'(rom_ce),   32'd1);
    check("first_rom_addr", rom_addr,      32'd0);
    check("first_id_valid", 32'(id_valid), 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("stream_valid", 32'(id_valid), 32'd1);
      check("stream_pc",    id_pc,         32'(4 * k));
      check("stream_inst",  id_inst,       32'h1000_0000 + 32'(k));
      tick();
    end

    // Back-pressure: fill to depth, hold pc, then drain in order.
    rst = 1'b1; id_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("bp_ce0",   32'(rom_ce), 32'd1);
    check("bp_addr0", rom_addr,    32'd0);
    tick();
    check("bp_ce1",   32'(rom_ce), 32'd1);
    check("bp_addr1", rom_addr,    32'd4);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_ce",   32'(rom_ce),   32'd0);
      check("bp_hold_addr", rom_addr,      32'd8);
      check("bp_hold_pc",   id_pc,         32'd0);
      check("bp_hold_vld",  32'(id_valid), 32'd1);
      tick();
    end
    id_ready = 1'b1;
    #1;
    check("bp_refill_ce", 32'(rom_ce), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_vld", 32'(id_valid), 32'd1);
      check("bp_drain_pc",  id_pc,         32'(4 * k));
      tick();
    end

    // Redirect while the queue is full.
    id_ready = 1'b0;
    tick(); tick(); tick();
    check("br_full_ce", 32'(rom_ce), 32'd0);
    br_taken = 1'b1; br_target = 32'h0000_0103;
    #1;
    check("br_now_vld", 32'(id_valid), 32'd0);
    check("br_now_ce",  32'(rom_ce),   32'd0);
    tick();
    br_taken = 1'b0;
    #1;
    check("br_n1_addr", rom_addr,      32'h0000_0100);
    check("br_n1_vld",  32'(id_valid), 32'd0);
    check("br_n1_ce",   32'(rom_ce),   32'd1);
    id_ready = 1'b1;
    tick();
    check("br_n2_vld",  32'(id_valid), 32'd1);
    check("br_n2_pc",   id_pc,         32'h0000_0100);
    check("br_n2_inst", id_inst,       32'h1000_0040);
    tick();
    check("br_n3_pc",   id_pc,         32'h0000_0104);

    // Reset pulse mid-stream with entries queued; overrides a redirect.
    id_ready = 1'b0;
    tick(); tick();
    check("rp_queued_vld", 32'(id_valid), 32'd1);
    rst = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0200;
    #1;
    check("rp_vld", 32'(id_valid), 32'd0);
    check("rp_pc",  id_pc,         32'd0);
    check("rp_ce",  32'(rom_ce),   32'd0);
    tick();
    rst = 1'b0; br_taken = 1'b0;
    #1;
    check("rp_after_vld",  32'(id_valid), 32'd0);
    check("rp_after_addr", rom_addr,      32'd0);
    check("rp_after_ce",   32'(rom_ce),   32'd1);
    id_ready = 1'b1;
    tick();
    check("rp_refetch_vld", 32'(id_valid), 32'd1);
    check("rp_refetch_pc",  id_pc,         32'd0);

    // Random decode back-pressure against an in-order scoreboard.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 32'd0;
    n_del = 0;
    for (int c = 0; c < 1000; c++) begin
      id_ready = 1'($urandom_range(0, 1));
      #1;
      if (id_valid && id_ready) begin
        check("rand_pc",   id_pc,   exp_pc);
        check("rand_inst", id_inst, 32'h1000_0000 + (exp_pc >> 2));
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      tick();
    end
    check("rand_throughput", 32'(n_del >= 300), 32'd1);

    // Wrap of pc across 2^32 on the second instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("wrap_addr0", w_rom_addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc0", w_id_pc, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc1", w_id_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc2",  w_id_pc,         32'h0000_0000);
    check("wrap_vld2", 32'(w_id_valid), 32'd1);
    tick();
    check("wrap_pc3", w_id_pc, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, is the fetch-queue depth in entries (power of two, ≥2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 br_taken  input  1  redirect request from execute; takes precedence over all other activity.
REQ-006 br_target  input  `AddrLen  redirect address; bits [1:0] ignored and treated as 00.
REQ-007 rom_ce  output  1  chip enable to instruction ROM (`ChipEnable / `ChipDisable).
REQ-008 rom_addr  output  `AddrLen  byte address to ROM; equals pc.
REQ-009 rom_inst  input  `InstLen  ROM read data, combinational in the same cycle as rom_addr.
REQ-010 id_valid  output  1  head queue entry is valid for decode.
REQ-011 id_pc  output  `AddrLen  pc of head entry.
REQ-012 id_inst  output  `InstLen  instruction of head entry.
REQ-013 id_ready  input  1  decode accepts the head entry this cycle.

Function
REQ-014 pc SHALL be a register; rom_addr SHALL equal pc every cycle.
REQ-015 push = rom_ce; rom_ce SHALL be `ChipEnable iff rst=0, br_taken=0 and (count<QDEPTH or pop).
REQ-016 On push, {pc, rom_inst} SHALL be written at the tail and pc SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-017 pop = id_valid & id_ready; on pop the head SHALL advance.
REQ-018 id_valid SHALL be (count≠0) & ~br_taken; id_pc/id_inst SHALL be the head entry, and `ZERO_WORD/0 when count=0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; push while full is allowed only with pop in the same cycle.
REQ-020 Fetch-to-decode latency SHALL be 1 cycle: a word fetched in cycle N appears at id_* in cycle N+1 at the earliest; no combinational bypass.
REQ-021 When br_taken=1: no push, no pop, queue flushed (count<=0, pointers<=0), pc<={br_target[31:2],2'b00} at the next edge.
REQ-022 After a redirect in cycle N, the target word SHALL be fetched in N+1 and presented with id_valid=1 in N+2.
REQ-023 With id_ready held 0 the block SHALL fill to QDEPTH entries then hold pc and deassert rom_ce, with no entry lost or duplicated.
REQ-024 Entries SHALL leave the queue in strict fetch order; each fetched pc SHALL be delivered exactly once unless flushed.
REQ-025 Pointers SHALL wrap modulo QDEPTH; count SHALL be $clog2(QDEPTH)+1 bits wide.

Reset
REQ-026 While rst=1: pc<=RESET_PC, count/pointers<=0, rom_ce=`ChipDisable, id_valid=0, id_pc=0, id_inst=`ZERO_WORD.
REQ-027 rst SHALL override br_taken; reset asserted mid-stream SHALL discard all queued entries.
REQ-028 The first fetch SHALL occur in the first cycle with rst=0, at RESET_PC.

Structure
REQ-029 `AddrLen, `InstLen, `ZERO_WORD, `ChipEnable and `ChipDisable SHALL come from the shared defines header; no local redefinition.
REQ-030 The queue SHALL be a sub-module fetch_queue (circular buffer, push/pop/flush, count), instantiated once; pc logic stays in if_stage.
REQ-031 Queue storage SHALL be registers (no RAM inference); the ROM is external to this block.

Verification
REQ-032 Reset release, id_ready=1, ROM word k = 32'h1000_0000+k -> id_pc 0,4,8,… on consecutive cycles from the 2nd cycle after reset, id_inst matching.
REQ-033 id_ready=0 for 5 cycles -> exactly 2 fetches (pc 0,4), then rom_ce=0 and pc=8; on id_ready=1, 0,4,8 delivered in order with no gap after 8.
REQ-034 br_taken=1, br_target=32'h0000_0103 while queue full -> next cycle pc=32'h100, id_valid=0; cycle after, id_pc=32'h100, id_valid=1; pre-redirect entries never delivered.
REQ-035 RESET_PC=32'hFFFF_FFF8, id_ready=1 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst=1 pulsed for 1 cycle with 2 entries queued -> id_valid=0 next cycle, then refetch from RESET_PC.
REQ-037 Random id_ready (50%) over 1000 cycles with a scoreboard -> delivered pc stream strictly +4, no drops, no duplicates.
